// File: rtl/sd_gearbox_unpack_pkg.sv
// Shared definitions for the srdy/drdy unpacking gearbox.
// Holds the word-count width helper and the state encoding.
package sd_gearbox_unpack_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_RATIO = 4;

  function automatic int cnt_bits(input int ratio);
    return $clog2(ratio + 1);
  endfunction

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_SEND  = 1'b1
  } ugb_state_e;

endpackage

// File: rtl/sd_gearbox_unpack.sv
// Wide-to-narrow gearbox: one beat of up to ratio words in,
// one word per cycle out, lowest word first.
module sd_gearbox_unpack
  import sd_gearbox_unpack_pkg::*;
#(
  parameter int width = DEF_WIDTH,
  parameter int ratio = DEF_RATIO,
  parameter int csz   = cnt_bits(ratio)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   c_srdy,
  output logic                   c_drdy,
  input  logic [width*ratio-1:0] c_data,
  input  logic [csz-1:0]         c_cnt,
  output logic                   p_srdy,
  input  logic                   p_drdy,
  output logic [width-1:0]       p_data,
  output logic                   p_last,
  output logic [csz-1:0]         usage
);

  logic [width*ratio-1:0] r_hold;
  logic [csz-1:0]         r_idx;
  logic [csz-1:0]         r_rem;

  logic [width*ratio-1:0] w_hold_nxt;
  logic [csz-1:0]         w_idx_nxt;
  logic [csz-1:0]         w_rem_nxt;
  logic [csz-1:0]         w_cnt;
  logic                   w_accept;
  logic                   w_xfer;
  logic [width-1:0]       w_word;
  ugb_state_e             w_state;

  assign w_state  = (r_rem == '0) ? ST_EMPTY : ST_SEND;
  assign w_cnt    = (c_cnt > csz'(ratio)) ? csz'(ratio) : c_cnt;
  assign w_accept = c_srdy & c_drdy;
  assign w_xfer   = p_srdy & p_drdy;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rem  <= '0;
      r_idx  <= '0;
      r_hold <= '0;
    end else begin
      r_rem  <= w_rem_nxt;
      r_idx  <= w_idx_nxt;
      r_hold <= w_hold_nxt;
    end
  end

  // Accept wins over transfer: it only fires once the last word is leaving.
  always_comb begin
    w_hold_nxt = r_hold;
    w_idx_nxt  = r_idx;
    w_rem_nxt  = r_rem;
    if (w_accept) begin
      w_hold_nxt = c_data;
      w_idx_nxt  = '0;
      w_rem_nxt  = w_cnt;
    end else if (w_xfer) begin
      w_idx_nxt  = r_idx + 1'b1;
      w_rem_nxt  = r_rem - 1'b1;
    end
  end

  always_comb begin
    w_word = '0;
    for (int k = 0; k < ratio; k++) begin
      if (r_idx == csz'(k)) w_word = r_hold[k*width +: width];
    end
  end

  always_comb begin
    c_drdy = 1'b0;
    p_srdy = 1'b0;
    p_last = 1'b0;
    p_data = w_word;
    usage  = r_rem;
    unique case (w_state)
      ST_EMPTY: c_drdy = !reset;
      ST_SEND: begin
        p_srdy = 1'b1;
        p_last = (r_rem == csz'(1));
        c_drdy = !reset & (r_rem == csz'(1)) & p_drdy;
      end
      default: ;
    endcase
  end

endmodule
